// File: rtl/bitmap_alloc_pkg.sv
// bitmap_alloc_pkg: shared widths and the free-legality helper for bitmap_alloc.
package bitmap_alloc_pkg;
    localparam int DEF_INWID  = 6;
    localparam int DEF_OUTWID = 48;
    localparam int CNTWID     = DEF_INWID + 1;

    function automatic int cntwid(input int inwid);
        return inwid + 1;
    endfunction

    // A free is legal only for an in-range index whose entry is allocated.
    function automatic logic free_legal(input int unsigned idx, input int unsigned outwid, input logic hit);
        return (idx < outwid) && hit;
    endfunction
endpackage

// File: rtl/bitmap_alloc_if.sv
// bitmap_alloc_if: allocate/free/status bundle of bitmap_alloc.
interface bitmap_alloc_if
    import bitmap_alloc_pkg::*;
#(
    parameter int INWID  = DEF_INWID,
    parameter int OUTWID = DEF_OUTWID
);
    logic                     clr;
    logic                     alloc_req;
    logic                     alloc_vld;
    logic [INWID-1:0]         alloc_idx;
    logic                     alloc_fail;
    logic                     free_vld;
    logic [INWID-1:0]         free_idx;
    logic                     free_err;
    logic [OUTWID-1:0]        map;
    logic [cntwid(INWID)-1:0] cnt;
    logic                     full;
    logic                     empty;

    modport master (
        output clr, alloc_req, free_vld, free_idx,
        input  alloc_vld, alloc_idx, alloc_fail, free_err, map, cnt, full, empty
    );
    modport slave (
        input  clr, alloc_req, free_vld, free_idx,
        output alloc_vld, alloc_idx, alloc_fail, free_err, map, cnt, full, empty
    );
endinterface

// File: rtl/bitmap_alloc_ffz_enc.sv
// ffz_enc: index of the lowest zero bit of map; none=1 when every bit is set.
module ffz_enc #(
    parameter int INWID  = 6,
    parameter int OUTWID = 48
) (
    input  logic [OUTWID-1:0] map,
    output logic [INWID-1:0]  idx,
    output logic              none
);
    always_comb begin
        idx = '0;
        for (int i = OUTWID - 1; i >= 0; i--)
            if (!map[i]) idx = INWID'(i);
        none = &map;
    end
endmodule

// File: rtl/bitmap_alloc.sv
// bitmap_alloc: lowest-free-first entry allocator with free, clear and occupancy count.
// Define BITMAP_ALLOC_ERR_EN to report illegal frees on free_err.
module bitmap_alloc
    import bitmap_alloc_pkg::*;
#(
    parameter int INWID  = DEF_INWID,
    parameter int OUTWID = DEF_OUTWID
) (
    input  logic          clk,
    input  logic          rst_n,
    bitmap_alloc_if.slave bus
);
    localparam int CW = cntwid(INWID);
    localparam int N  = 2 ** INWID;

    logic [OUTWID-1:0] map_q, map_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [INWID-1:0]  idx_q, cand;
    logic [N-1:0]      map_x;
    logic              vld_q, fail_q, err_q, none, full, grant, legal, rel, bad;

    ffz_enc #(.INWID(INWID), .OUTWID(OUTWID)) u_ffz (.map(map_q), .idx(cand), .none(none));

    // Widened copy so any free_idx can be looked up without leaving the vector.
    assign map_x = N'(map_q);
    assign full  = cnt_q == CW'(OUTWID);
    assign grant = bus.alloc_req && !none;
    assign legal = free_legal(32'(bus.free_idx), OUTWID, map_x[bus.free_idx]);
    assign rel   = bus.free_vld && legal;
`ifdef BITMAP_ALLOC_ERR_EN
    assign bad = bus.free_vld && !legal;
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        map_d = map_q;
        if (grant) map_d[cand] = 1'b1;
        if (rel) map_d[bus.free_idx] = 1'b0;
        cnt_d = cnt_q + CW'(grant) - CW'(rel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            fail_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.clr) begin
            map_q  <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            fail_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            map_q  <= map_d;
            cnt_q  <= cnt_d;
            vld_q  <= grant;
            fail_q <= bus.alloc_req && none;
            err_q  <= bad;
            if (grant) idx_q <= cand;
        end
    end

    assign bus.map        = map_q;
    assign bus.cnt        = cnt_q;
    assign bus.alloc_idx  = idx_q;
    assign bus.alloc_vld  = vld_q;
    assign bus.alloc_fail = fail_q;
    assign bus.free_err   = err_q;
    assign bus.full       = full;
    assign bus.empty      = cnt_q == '0;
endmodule

// File: tb/tb_bitmap_alloc.sv
// tb_bitmap_alloc: directed scenarios plus randomized traffic against an array model.
module tb_bitmap_alloc;
    localparam int INWID  = 6;
    localparam int OUTWID = 48;
`ifdef BITMAP_ALLOC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bitmap_alloc_if #(.INWID(INWID), .OUTWID(OUTWID)) bus ();
    bitmap_alloc #(.INWID(INWID), .OUTWID(OUTWID)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit mdl[OUTWID];
    logic e_vld, e_fail, e_err;
    logic [INWID-1:0] e_idx;

    function automatic logic [OUTWID-1:0] mdl_map();
        logic [OUTWID-1:0] m;
        for (int i = 0; i < OUTWID; i++) m[i] = mdl[i];
        return m;
    endfunction

    function automatic int mdl_cnt();
        int n = 0;
        for (int i = 0; i < OUTWID; i++) n += int'(mdl[i]);
        return n;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < OUTWID; i++) mdl[i] = 1'b0;
        e_vld = 0; e_fail = 0; e_err = 0;
    endtask

    // One clock of stimulus; the model takes the same step from the pre-edge state.
    task automatic drive(input logic req, input logic fv, input int fi, input logic c);
        int cand;
        bit legal;
        @(negedge clk);
        bus.alloc_req = req; bus.free_vld = fv; bus.free_idx = INWID'(fi); bus.clr = c;
        cand = -1;
        for (int i = 0; i < OUTWID; i++) if (!mdl[i] && cand < 0) cand = i;
        if (c) mdl_clear();
        else begin
            legal = (fi < OUTWID) ? mdl[fi] : 1'b0;
            e_vld = req && cand >= 0;
            e_fail = req && cand < 0;
            e_err = ERR_EN && fv && !legal;
            if (e_vld) begin mdl[cand] = 1'b1; e_idx = INWID'(cand); end
            if (fv && legal) mdl[fi] = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.alloc_req = 0; bus.free_vld = 0; bus.clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        bus.alloc_req = 0; bus.free_vld = 0; bus.free_idx = '0; bus.clr = 0;
        mdl_clear();
        e_idx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.map !== '0 || bus.cnt !== '0 || bus.alloc_idx !== '0 || bus.alloc_vld !== 0 ||
            bus.alloc_fail !== 0 || bus.free_err !== 0 || bus.empty !== 1 || bus.full !== 0) begin
            errors++;
            $display("FAIL reset map=%h cnt=%0d idx=%0d vld=%b fail=%b err=%b empty=%b full=%b want all zero, empty=1",
                     bus.map, bus.cnt, bus.alloc_idx, bus.alloc_vld, bus.alloc_fail, bus.free_err, bus.empty, bus.full);
        end
    endtask

    task automatic test_seq_alloc();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0);
            checks++;
            if (bus.alloc_vld !== 1 || bus.alloc_idx !== INWID'(i)) begin
                errors++;
                $display("FAIL seq_alloc vld=%b idx=%0d want 1/%0d", bus.alloc_vld, bus.alloc_idx, i);
            end
        end
        checks++;
        if (bus.map !== 48'h7 || bus.cnt !== 7'd3) begin
            errors++;
            $display("FAIL seq_map map=%h cnt=%0d want 7/3", bus.map, bus.cnt);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (bus.alloc_vld !== 0 || bus.alloc_idx !== 6'd2) begin
            errors++;
            $display("FAIL idle_hold vld=%b idx=%0d want 0/2", bus.alloc_vld, bus.alloc_idx);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < OUTWID; i++) begin
            drive(1, 0, 0, 0);
            checks++;
            if (bus.alloc_vld !== 1 || bus.alloc_idx !== INWID'(i)) begin
                errors++;
                $display("FAIL fill vld=%b idx=%0d want 1/%0d", bus.alloc_vld, bus.alloc_idx, i);
            end
        end
        drive(1, 0, 0, 0);
        checks++;
        if (bus.full !== 1 || bus.alloc_fail !== 1 || bus.alloc_vld !== 0 || bus.map !== 48'hFFFF_FFFF_FFFF || bus.cnt !== 7'd48) begin
            errors++;
            $display("FAIL overflow full=%b fail=%b vld=%b map=%h cnt=%0d want 1/1/0/ffffffffffff/48",
                     bus.full, bus.alloc_fail, bus.alloc_vld, bus.map, bus.cnt);
        end
        drive(1, 1, 10, 0);
        checks++;
        if (bus.alloc_fail !== 1 || bus.alloc_vld !== 0 || bus.map !== 48'hFFFF_FFFF_FBFF || bus.cnt !== 7'd47) begin
            errors++;
            $display("FAIL full_free fail=%b vld=%b map=%h cnt=%0d want 1/0/fffffffffbff/47",
                     bus.alloc_fail, bus.alloc_vld, bus.map, bus.cnt);
        end
        drive(1, 0, 0, 0);
        checks++;
        if (bus.alloc_vld !== 1 || bus.alloc_idx !== 6'd10 || bus.full !== 1) begin
            errors++;
            $display("FAIL refill vld=%b idx=%0d full=%b want 1/10/1", bus.alloc_vld, bus.alloc_idx, bus.full);
        end
        drive(1, 1, 3, 1);
        checks++;
        if (bus.map !== '0 || bus.cnt !== '0 || bus.empty !== 1 || bus.alloc_vld !== 0 || bus.alloc_fail !== 0 || bus.free_err !== 0) begin
            errors++;
            $display("FAIL clr map=%h cnt=%0d empty=%b vld=%b fail=%b err=%b want 0/0/1/0/0/0",
                     bus.map, bus.cnt, bus.empty, bus.alloc_vld, bus.alloc_fail, bus.free_err);
        end
    endtask

    task automatic test_free_realloc();
        do_reset();
        repeat (3) drive(1, 0, 0, 0);
        drive(0, 1, 1, 0);
        checks++;
        if (bus.map !== 48'h5 || bus.cnt !== 7'd2 || bus.free_err !== 0) begin
            errors++;
            $display("FAIL free1 map=%h cnt=%0d err=%b want 5/2/0", bus.map, bus.cnt, bus.free_err);
        end
        drive(1, 0, 0, 0);
        checks++;
        if (bus.alloc_vld !== 1 || bus.alloc_idx !== 6'd1) begin
            errors++;
            $display("FAIL realloc vld=%b idx=%0d want 1/1", bus.alloc_vld, bus.alloc_idx);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (3) drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        checks++;
        if (bus.alloc_vld !== 1 || bus.alloc_idx !== 6'd3 || bus.map !== 48'hE || bus.cnt !== 7'd3) begin
            errors++;
            $display("FAIL simul vld=%b idx=%0d map=%h cnt=%0d want 1/3/e/3", bus.alloc_vld, bus.alloc_idx, bus.map, bus.cnt);
        end
    endtask

    task automatic test_illegal_free();
        do_reset();
        repeat (3) drive(1, 0, 0, 0);
        drive(0, 1, 50, 0);
        checks++;
        if (bus.free_err !== ERR_EN || bus.map !== 48'h7 || bus.cnt !== 7'd3) begin
            errors++;
            $display("FAIL free_range err=%b map=%h cnt=%0d want %b/7/3", bus.free_err, bus.map, bus.cnt, ERR_EN);
        end
        drive(0, 1, 5, 0);
        checks++;
        if (bus.free_err !== ERR_EN || bus.map !== 48'h7 || bus.cnt !== 7'd3) begin
            errors++;
            $display("FAIL free_unset err=%b map=%h cnt=%0d want %b/7/3", bus.free_err, bus.map, bus.cnt, ERR_EN);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (bus.free_err !== 0) begin
            errors++;
            $display("FAIL err_pulse err=%b want 0", bus.free_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) drive(1, 0, 0, 0);
        @(negedge clk);
        bus.alloc_req = 1;
        #2 rst_n = 0;
        #1;
        mdl_clear();
        e_idx = '0;
        checks++;
        if (bus.map !== '0 || bus.cnt !== '0 || bus.alloc_idx !== '0 || bus.alloc_vld !== 0) begin
            errors++;
            $display("FAIL async_rst map=%h cnt=%0d idx=%0d vld=%b want 0/0/0/0", bus.map, bus.cnt, bus.alloc_idx, bus.alloc_vld);
        end
        @(posedge clk);
        @(negedge clk);
        bus.alloc_req = 0;
        rst_n = 1;
        drive(1, 0, 0, 0);
        checks++;
        if (bus.alloc_vld !== 1 || bus.alloc_idx !== 6'd0 || bus.map !== 48'h1) begin
            errors++;
            $display("FAIL post_rst vld=%b idx=%0d map=%h want 1/0/1", bus.alloc_vld, bus.alloc_idx, bus.map);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 45),
                  int'($urandom_range(0, 99) < 85 ? $urandom_range(0, OUTWID - 1) : $urandom_range(0, 63)),
                  logic'($urandom_range(0, 99) < 2));
            checks++;
            if (bus.alloc_vld !== e_vld || bus.alloc_fail !== e_fail || bus.free_err !== e_err || bus.alloc_idx !== e_idx) begin
                errors++;
                $display("FAIL rand_pulse n=%0d vld=%b fail=%b err=%b idx=%0d want %b/%b/%b/%0d",
                         n, bus.alloc_vld, bus.alloc_fail, bus.free_err, bus.alloc_idx, e_vld, e_fail, e_err, e_idx);
            end
            checks++;
            if (bus.map !== mdl_map() || bus.cnt !== 7'(mdl_cnt()) ||
                bus.full !== (mdl_cnt() == OUTWID) || bus.empty !== (mdl_cnt() == 0)) begin
                errors++;
                $display("FAIL rand_state n=%0d map=%h cnt=%0d full=%b empty=%b want %h/%0d",
                         n, bus.map, bus.cnt, bus.full, bus.empty, mdl_map(), mdl_cnt());
            end
        end
    endtask

    initial begin
        bus.alloc_req = 0; bus.free_vld = 0; bus.free_idx = '0; bus.clr = 0;
        test_reset();
        test_seq_alloc();
        test_full();
        test_free_realloc();
        test_simultaneous();
        test_illegal_free();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitmap_alloc.md
BITMAP_ALLOC -- requirements
Module: bitmap_alloc

Interface
REQ-001 SHALL have parameter INWID, default 6, width of every index port.
REQ-002 SHALL have parameter OUTWID, default 48, number of bitmap entries; OUTWID <= 2**INWID.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear of all entries.
REQ-006 SHALL have port alloc_req  input  1  request for one free entry.
REQ-007 SHALL have port alloc_vld  output  1  registered grant pulse.
REQ-008 SHALL have port alloc_idx  output  INWID  granted index, meaningful while alloc_vld=1.
REQ-009 SHALL have port alloc_fail  output  1  registered pulse: request refused, map full.
REQ-010 SHALL have port free_vld  input  1  release strobe.
REQ-011 SHALL have port free_idx  input  INWID  index to release.
REQ-012 SHALL have port free_err  output  1  registered illegal-free pulse.
REQ-013 SHALL have port map  output  OUTWID  bitmap register; bit i=1 means entry i allocated.
REQ-014 SHALL have port cnt  output  INWID+1  number of allocated entries.
REQ-015 SHALL have ports full and empty  output  1 each  cnt==OUTWID and cnt==0, decoded from registers.

Function
REQ-016 SHALL compute the candidate as the lowest-numbered zero bit of the current map register.
REQ-017 SHALL, on alloc_req=1 and full=0 at an edge, set the candidate bit, assert alloc_vld and load alloc_idx with the candidate, one cycle latency.
REQ-018 SHALL, on alloc_req=1 and full=1, leave map unchanged and assert alloc_fail for one cycle.
REQ-019 SHALL hold alloc_vld, alloc_fail and free_err low in any cycle without the matching event; alloc_idx holds its last value.
REQ-020 SHALL, on legal free_vld, clear map[free_idx] at the edge; a free is legal when free_idx < OUTWID and the map bit is 1.
REQ-021 SHALL treat alloc and free in the same cycle as both using the pre-edge map: a freed index is not re-granted that cycle; cnt is unchanged.
REQ-022 SHALL refuse the allocation when full=1, even if a legal free arrives in the same cycle; the free still applies.
REQ-023 SHALL update cnt by +1 per grant, -1 per legal free, net in one cycle; cnt never wraps.
REQ-024 SHALL, on clr=1, zero map and cnt, drive all pulses low, and ignore alloc_req and free_vld that cycle.

Reset
REQ-025 SHALL, while rst_n=0, force map=0, cnt=0, alloc_idx=0, alloc_vld=0, alloc_fail=0, free_err=0; hence empty=1 and full=0.
REQ-026 SHALL drop any request in flight when reset asserts mid-operation; the first grant after reset release is index 0.

Configuration
REQ-027 SHALL, with BITMAP_ALLOC_ERR_EN defined, pulse free_err one cycle after any illegal free.
REQ-028 SHALL, without BITMAP_ALLOC_ERR_EN, tie free_err to 0 and still ignore illegal frees.

Structure
REQ-029 SHALL take CNTWID (INWID+1) and the free-legality helper from shared package bitmap_alloc_pkg.
REQ-030 SHALL place the lowest-zero search in sub-module ffz_enc, parameterised INWID/OUTWID, outputs idx and none.

Verification (INWID=6, OUTWID=48)
REQ-031 SHALL check that after reset, 3 back-to-back alloc_req give alloc_idx 0,1,2, map=0x7, and cnt=3.
REQ-032 SHALL check that 48 allocs followed by a 49th request give full=1 and alloc_fail=1, and map stays 0xFFFF_FFFF_FFFF.
REQ-033 SHALL check that with map=0x7, freeing 1 then allocating gives alloc_idx=1.
REQ-034 SHALL check that with map=0x7, a simultaneous free 0 and alloc gives alloc_idx=3, map=0xE, and cnt=3.
REQ-035 SHALL check that free_idx=50, or freeing free index 5, gives free_err=1 with ERR_EN and 0 without; map is unchanged in both cases.
REQ-036 SHALL check that clr=1 together with alloc_req on a full map gives map=0, cnt=0, empty=1, alloc_vld=0, and alloc_fail=0.
